alarm_ring_controller: RTL and testbench
========================================

// Module: alarm_ring_controller
// PURPOSE
//  Consumes the alarm-active flag (aa) produced by the 7-register CT comparator stage and runs the alarm sequence.
//  Sequence: ring (pulsed buzzer), snooze, stop, auto-timeout, and re-arm lockout until the matching minute ends.
//  Sits between the comparators and the buzzer/LED drivers; time base is the 1 Hz tick from the clock counter.
// PARAMETERS
//  RING_MAX_S   60   seconds of continuous ringing before auto-stop
//  SNOOZE_S     300  seconds of silence per snooze
//  SNOOZE_MAX   3    snoozes allowed per alarm event; further snooze presses ignored
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  tick_1hz   in   1  one-clk pulse per second
//  aa         in   1  alarm active from comparators (level, high for the whole matching minute)
//  enable     in   1  alarm master switch; low forces IDLE
//  snooze_btn in   1  debounced single-clk pulse
//  stop_btn   in   1  debounced single-clk pulse
//  buzzer     out  1  buzzer drive, 0.5 Hz pattern (1 s on / 1 s off)
//  ringing    out  1  state==RINGING
//  snoozing   out  1  state==SNOOZE
//  snooze_cnt out  $clog2(SNOOZE_MAX+1)  snoozes used in current event
// BEHAVIOUR
//  Reset: state=IDLE, aa_q=0, timer=0, phase=0, snooze_cnt=0; all outputs 0.
//  Outputs are Moore-decoded from registers: buzzer = ringing & phase.
//  Edge detection:
//   - aa_q <= aa every clk; rise = aa & ~aa_q.
//   - aa high out of reset counts as a rise, because aa_q resets to 0.
//  States and transitions, evaluated at each clk edge:
//   - IDLE -> RINGING on rise & enable.
//     ringing=1 right after the first edge that samples aa=1; buzzer=1 same cycle.
//   - RINGING: on tick, phase toggles and timer decrements.
//     On entry: timer=RING_MAX_S, phase=1.
//     - stop_btn -> LOCKOUT.
//     - snooze_btn with snooze_cnt<SNOOZE_MAX -> SNOOZE. Same edge: timer=SNOOZE_S, snooze_cnt+1.
//     - snooze_btn with snooze_cnt==SNOOZE_MAX: ignored, keeps ringing.
//     - tick with timer==1 -> LOCKOUT. Rings exactly RING_MAX_S ticks.
//   - SNOOZE:
//     - stop_btn -> LOCKOUT.
//     - tick with timer==1 -> RINGING (timer=RING_MAX_S, phase=1).
//     - aa rises/falls ignored.
//   - LOCKOUT -> IDLE on the first edge sampling aa=0.
//     snooze_cnt cleared on entry to IDLE. Prevents re-trigger within the same minute after stop.
//  Priority in one cycle: ~enable > stop_btn > snooze_btn > tick expiry.
//   - A button coinciding with tick wins; the tick does not decrement the new timer.
//  enable low in any state -> IDLE next edge, snooze_cnt=0, buzzer off.
//   - Re-enabling while aa is high does not ring, since no rise is seen.
//  Back-to-back alarms (aa never drops between consecutive minutes) form one event; no second rise.
//  Timer width: $clog2(max(RING_MAX_S,SNOOZE_S)+1); never wraps, since it is only reloaded or decremented from >=1.
//  rst_n asserted mid-ring: buzzer drops immediately (async), state returns to IDLE.
// STRUCTURE
//  alarm_defs.vh: state encodings IDLE=2'd0, RINGING=2'd1, SNOOZE=2'd2, LOCKOUT=2'd3; shared with the LED/display stage.
//  Sub-module alarm_sec_timer: loadable tick-driven down-counter.
//   - Inputs: load, load_val, tick. Output: expire = (cnt==1)&tick.
//   - Reused by the future display-timeout block.
// TESTING (RING_MAX_S=5, SNOOZE_S=4, SNOOZE_MAX=2, tick every 10 clk)
//  aa 0->1, enable=1 -> ringing=1, buzzer=1 next edge; buzzer toggles each tick; after 5 ticks ringing=0, state=LOCKOUT; aa=0 -> IDLE.
//  snooze at 2nd tick -> snoozing=1, snooze_cnt=1, buzzer=0; 4 ticks later ringing=1, buzzer=1.
//  Snooze twice, then third snooze_btn -> ignored: ringing stays 1, snooze_cnt=2; stop_btn -> LOCKOUT, snooze_cnt=0 once aa=0.
//  stop_btn with aa still high -> LOCKOUT, no re-ring while aa=1; aa 0 then 1 -> rings again.
//  stop_btn and snooze_btn in same cycle -> LOCKOUT; snooze_btn coincident with tick -> SNOOZE with timer=4.
//  rst_n low mid-ring -> buzzer=0 without clk; enable low in SNOOZE -> IDLE; enable high with aa=1 -> no ring.

Source files
------------

// File: rtl/alarm_ring_controller_pkg.sv
// Shared definitions for the alarm ring controller: state encodings (also used
// by the LED/display stage) and a small constant helper for sizing counters.
package alarm_ring_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    // Larger of two parameters, used to size the shared seconds timer.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_sec_timer.sv
// Loadable down-counter stepped by a 1 Hz tick. expire flags the tick that
// consumes the last remaining second; load takes priority over the tick.
module alarm_sec_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            // Held at zero rather than wrapping if ticked while empty.
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = tick && (cnt_q == W'(1));

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm sequencer: rings on a rising alarm-active flag, supports a bounded number
// of snoozes, auto-stops after a ring timeout, and locks out until the minute ends.
module alarm_ring_controller
    import alarm_ring_controller_pkg::*;
#(
    parameter int  RING_MAX_S = 60,
    parameter int  SNOOZE_S   = 300,
    parameter int  SNOOZE_MAX = 3,
    localparam int CW         = $clog2(SNOOZE_MAX + 1),
    localparam int TW         = $clog2(max2(RING_MAX_S, SNOOZE_S) + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_1hz,
    input  logic          aa,
    input  logic          enable,
    input  logic          snooze_btn,
    input  logic          stop_btn,
    output logic          buzzer,
    output logic          ringing,
    output logic          snoozing,
    output logic [CW-1:0] snooze_cnt,
    output logic [1:0]    state_dbg
);

    localparam logic [TW-1:0] RING_LOAD   = TW'(RING_MAX_S);
    localparam logic [TW-1:0] SNOOZE_LOAD = TW'(SNOOZE_S);
    localparam logic [CW-1:0] SNOOZE_LIM  = CW'(SNOOZE_MAX);

    state_t        state_q;
    state_t        state_d;
    logic          aa_q;
    logic          phase_q;
    logic          phase_d;
    logic [CW-1:0] snz_q;
    logic [CW-1:0] snz_d;

    logic          rise;
    logic          tick_run;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expire;

    assign rise     = aa && !aa_q;
    // The timer only runs while a ring or snooze period is in progress.
    assign tick_run = tick_1hz && ((state_q == ST_RINGING) || (state_q == ST_SNOOZE));

    alarm_sec_timer #(
        .W (TW)
    ) u_sec_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tick_run),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        snz_d    = snz_q;
        tmr_load = 1'b0;
        tmr_val  = RING_LOAD;

        if (!enable) begin
            state_d = ST_IDLE;
            phase_d = 1'b0;
            snz_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d  = ST_RINGING;
                        phase_d  = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = RING_LOAD;
                    end
                end
                ST_RINGING: begin
                    if (stop_btn) begin
                        state_d = ST_LOCKOUT;
                        phase_d = 1'b0;
                    end else if (snooze_btn && (snz_q < SNOOZE_LIM)) begin
                        // A coincident tick is absorbed by the reload.
                        state_d  = ST_SNOOZE;
                        phase_d  = 1'b0;
                        snz_d    = snz_q + CW'(1);
                        tmr_load = 1'b1;
                        tmr_val  = SNOOZE_LOAD;
                    end else if (tmr_expire) begin
                        state_d = ST_LOCKOUT;
                        phase_d = 1'b0;
                    end else if (tick_run) begin
                        phase_d = !phase_q;
                    end
                end
                ST_SNOOZE: begin
                    if (stop_btn) begin
                        state_d = ST_LOCKOUT;
                    end else if (tmr_expire) begin
                        state_d  = ST_RINGING;
                        phase_d  = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = RING_LOAD;
                    end
                end
                ST_LOCKOUT: begin
                    // Holds until the matching minute ends so a stop is not undone.
                    if (!aa) begin
                        state_d = ST_IDLE;
                        snz_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    phase_d = 1'b0;
                    snz_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            aa_q    <= 1'b0;
            phase_q <= 1'b0;
            snz_q   <= '0;
        end else begin
            state_q <= state_d;
            aa_q    <= aa;
            phase_q <= phase_d;
            snz_q   <= snz_d;
        end
    end

    assign ringing    = (state_q == ST_RINGING);
    assign snoozing   = (state_q == ST_SNOOZE);
    assign buzzer     = ringing && phase_q;
    assign snooze_cnt = snz_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Bench for alarm_ring_controller: a seconds-counting reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_alarm_ring_controller;
  import alarm_ring_controller_pkg::*;

  localparam int RING = 5;
  localparam int SNZ  = 4;
  localparam int SMAX = 2;
  localparam int TDIV = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       aa = 1'b0;
  logic       enable = 1'b1;
  logic       snooze_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_cnt;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int tick_div = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alarm_ring_controller #(
    .RING_MAX_S (RING),
    .SNOOZE_S   (SNZ),
    .SNOOZE_MAX (SMAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .aa         (aa),
    .enable     (enable),
    .snooze_btn (snooze_btn),
    .stop_btn   (stop_btn),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt),
    .state_dbg  (state_dbg)
  );

  // ---------------- reference model ----------------
  // Counts elapsed seconds within the current ring/snooze period and the
  // snoozes used; outputs follow directly from those counts.
  state_t m_state = ST_IDLE;
  bit     m_aa_prev = 1'b0;
  int     m_secs = 0;
  int     m_snz = 0;

  always @(posedge clk or negedge rst_n) begin
    state_t ns;
    int     nsecs;
    int     nsnz;
    if (!rst_n) begin
      m_state   <= ST_IDLE;
      m_aa_prev <= 1'b0;
      m_secs    <= 0;
      m_snz     <= 0;
    end else begin
      ns    = m_state;
      nsecs = m_secs;
      nsnz  = m_snz;
      if (!enable) begin
        ns   = ST_IDLE;
        nsnz = 0;
      end else if (m_state == ST_IDLE) begin
        if (aa && !m_aa_prev) begin
          ns    = ST_RINGING;
          nsecs = 0;
        end
      end else if (m_state == ST_RINGING) begin
        if (stop_btn) ns = ST_LOCKOUT;
        else if (snooze_btn && m_snz < SMAX) begin
          ns    = ST_SNOOZE;
          nsecs = 0;
          nsnz  = m_snz + 1;
        end else if (tick_1hz) begin
          nsecs = m_secs + 1;
          if (nsecs == RING) ns = ST_LOCKOUT;
        end
      end else if (m_state == ST_SNOOZE) begin
        if (stop_btn) ns = ST_LOCKOUT;
        else if (tick_1hz) begin
          nsecs = m_secs + 1;
          if (nsecs == SNZ) begin
            ns    = ST_RINGING;
            nsecs = 0;
          end
        end
      end else begin
        if (!aa) begin
          ns   = ST_IDLE;
          nsnz = 0;
        end
      end
      m_state   <= ns;
      m_secs    <= nsecs;
      m_snz     <= nsnz;
      m_aa_prev <= aa;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit exp_ring;
    exp_ring = (m_state == ST_RINGING);
    check("model_ringing", int'(ringing), int'(exp_ring));
    check("model_snoozing", int'(snoozing), int'(m_state == ST_SNOOZE));
    check("model_buzzer", int'(buzzer), int'(exp_ring && (m_secs % 2 == 0)));
    check("model_snooze_cnt", int'(snooze_cnt), m_snz);
    check("model_state", int'(state_dbg), int'(m_state));
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit snz, input bit stp);
    @(negedge clk);
    tick_1hz   = (tick_div == TDIV - 1);
    tick_div   = (tick_div + 1) % TDIV;
    snooze_btn = snz;
    stop_btn   = stp;
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    int got = 0;
    for (int i = 0; i < (n + 1) * TDIV && got < n; i++) begin
      step(1'b0, 1'b0);
      if (tick_1hz) got++;
    end
    if (got != n) check("run_ticks_budget", got, n);
  endtask

  task automatic press(input bit snz, input bit stp);
    if (tick_div == TDIV - 1) step(1'b0, 1'b0);
    step(snz, stp);
  endtask

  task automatic press_at_tick(input bit snz, input bit stp);
    for (int i = 0; i < TDIV && tick_div != TDIV - 1; i++) step(1'b0, 1'b0);
    step(snz, stp);
    check("press_at_tick_aligned", int'(tick_1hz), 1);
  endtask

  task automatic set_aa(input bit v);
    aa = v;
    step(1'b0, 1'b0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("reset_ringing", int'(ringing), 0);
    check("reset_buzzer", int'(buzzer), 0);
    check("reset_snoozing", int'(snoozing), 0);
    check("reset_snooze_cnt", int'(snooze_cnt), 0);
    check("reset_state", int'(state_dbg), 0);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0);

    // Basic ring, buzzer cadence, auto-timeout, lockout release.
    set_aa(1'b1);
    check("s1_ring_on", int'(ringing), 1);
    check("s1_buzz_on", int'(buzzer), 1);
    run_ticks(1);
    check("s1_buzz_off_tick1", int'(buzzer), 0);
    run_ticks(3);
    check("s1_still_ring_tick4", int'(ringing), 1);
    check("s1_buzz_on_tick4", int'(buzzer), 1);
    run_ticks(1);
    check("s1_timeout_ringing", int'(ringing), 0);
    check("s1_timeout_lockout", int'(state_dbg), 3);
    set_aa(1'b0);
    check("s1_idle", int'(state_dbg), 0);

    // Snooze on the 2nd tick, snooze again, then an ignored third snooze.
    set_aa(1'b1);
    run_ticks(1);
    press_at_tick(1'b1, 1'b0);
    check("s2_snoozing", int'(snoozing), 1);
    check("s2_snz_cnt1", int'(snooze_cnt), 1);
    check("s2_buzz_off", int'(buzzer), 0);
    run_ticks(3);
    check("s2_still_snoozing", int'(snoozing), 1);
    run_ticks(1);
    check("s2_rering", int'(ringing), 1);
    check("s2_rering_buzz", int'(buzzer), 1);
    press(1'b1, 1'b0);
    check("s2_snz_cnt2", int'(snooze_cnt), 2);
    run_ticks(4);
    press(1'b1, 1'b0);
    check("s2_third_ignored", int'(ringing), 1);
    check("s2_cnt_held", int'(snooze_cnt), 2);
    press(1'b0, 1'b1);
    check("s2_stop_lockout", int'(state_dbg), 3);
    check("s2_cnt_in_lockout", int'(snooze_cnt), 2);
    set_aa(1'b0);
    check("s2_cnt_cleared", int'(snooze_cnt), 0);

    // Stop while aa high: no re-ring until aa drops and rises again.
    set_aa(1'b1);
    press(1'b0, 1'b1);
    check("s3_lockout", int'(state_dbg), 3);
    repeat (25) step(1'b0, 1'b0);
    check("s3_no_rering", int'(ringing), 0);
    set_aa(1'b0);
    set_aa(1'b1);
    check("s3_rings_again", int'(ringing), 1);

    // Stop and snooze together; snooze coincident with tick.
    press(1'b1, 1'b1);
    check("s4_stop_wins", int'(state_dbg), 3);
    set_aa(1'b0);
    set_aa(1'b1);
    press_at_tick(1'b1, 1'b0);
    check("s4_snooze_on_tick", int'(snoozing), 1);
    run_ticks(3);
    check("s4_full_snooze", int'(snoozing), 1);
    run_ticks(1);
    check("s4_ring_after4", int'(ringing), 1);

    // Asynchronous reset mid-ring.
    check("s5_buzz_before", int'(buzzer), 1);
    #1 rst_n = 1'b0;
    tick_1hz = 1'b0;
    #1;
    check("s5_async_buzz", int'(buzzer), 0);
    check("s5_async_ring", int'(ringing), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    check("s5_aa_high_out_of_reset", int'(ringing), 1);

    // Enable low in snooze, then re-enable with aa high.
    press(1'b1, 1'b0);
    check("s6_snoozing", int'(snoozing), 1);
    enable = 1'b0;
    step(1'b0, 1'b0);
    check("s6_disable_idle", int'(state_dbg), 0);
    check("s6_disable_cnt", int'(snooze_cnt), 0);
    enable = 1'b1;
    repeat (12) step(1'b0, 1'b0);
    check("s6_no_ring_reenable", int'(ringing), 0);
    set_aa(1'b0);
    set_aa(1'b1);
    check("s6_ring_new_rise", int'(ringing), 1);
    press(1'b0, 1'b1);
    repeat (15) step(1'b0, 1'b0);
    check("s6_back_to_back", int'(state_dbg), 3);
    set_aa(1'b0);
    repeat (3) step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
